pe_array_dummy_stim_ctrl: RTL



---
 rtl/pe_array_dummy_stim_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_dummy_stim_ctrl.sv
// Dummy stimulus controller for the PE-array data-in wrapper: serial weight load
// into per-column registers, then LFSR-driven compressed activations with tunable sparsity.
module pe_array_dummy_stim_ctrl #(
  parameter int unsigned num_pe_row           = 16,
  parameter int unsigned num_pe_col           = 16,
  parameter int unsigned nb_taps              = 11,
  parameter int unsigned activation_width     = 16,
  parameter int unsigned compressed_act_width = activation_width + 1,
  parameter int unsigned weight_width         = 16,
  parameter int unsigned ETC_width            = 4,
  parameter int unsigned weight_bpr_width     = ((weight_width + 1) / 2) * 3
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    start,
  input  logic                                                    load_w,
  input  logic [15:0]                                             num_act_cycles,
  input  logic [8:0]                                              zero_thresh,
  input  logic [1:0]                                              ext_act_sel,
  input  logic                                                    ext_last_row_sel,
  input  logic                                                    ext_wreg_sel,
  input  logic                                                    w_in_valid,
  output logic                                                    w_in_ready,
  input  logic [weight_width-1:0]                                 w_in_data,
  input  logic [weight_bpr_width-1:0]                             w_in_bpr,
  input  logic [ETC_width-1:0]                                    w_in_etc,
  output logic [num_pe_row-1:0][compressed_act_width-1:0]         compressed_act_in_fr_dummy_ctrl,
  output logic [num_pe_col-1:0][compressed_act_width-1:0]         last_row_shadow_AFIFO_data_in_fr_dummy_ctrl,
  output logic [num_pe_col-1:0][weight_width*nb_taps-1:0]         WRegs_fr_dummy_ctrl,
  output logic [num_pe_col-1:0][weight_bpr_width*nb_taps-1:0]     WBPRs_fr_dummy_ctrl,
  output logic [num_pe_col-1:0][ETC_width*nb_taps-1:0]            WETCs_fr_dummy_ctrl,
  output logic                                                    act_valid,
  output logic [1:0]                                              compressed_act_in_sel,
  output logic                                                    last_row_shadow_afifo_in_sel,
  output logic                                                    wreg_in_sel,
  output logic                                                    busy,
  output logic                                                    done
);

  localparam int unsigned COL_W = (num_pe_col > 1) ? $clog2(num_pe_col) : 1;
  localparam int unsigned TAP_W = (nb_taps > 1) ? $clog2(nb_taps) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DONE} state_e;

  state_e                                                state_q, state_d;
  logic [15:0]                                           cnt_q, cnt_d, num_q, num_d;
  logic [8:0]                                            thr_q, thr_d;
  logic [COL_W-1:0]                                      wcol_q, wcol_d;
  logic [TAP_W-1:0]                                      wtap_q, wtap_d;
  logic [num_pe_row-1:0][31:0]                           lfsr_q, lfsr_d, lfsr_nxt;
  logic [num_pe_row-1:0][compressed_act_width-1:0]       act_q, act_d;
  logic [num_pe_col-1:0][compressed_act_width-1:0]       shadow_q, shadow_d;
  logic [num_pe_col-1:0][weight_width*nb_taps-1:0]       wreg_q, wreg_d;
  logic [num_pe_col-1:0][weight_bpr_width*nb_taps-1:0]   wbpr_q, wbpr_d;
  logic [num_pe_col-1:0][ETC_width*nb_taps-1:0]          wetc_q, wetc_d;
  logic                                                  act_valid_q, act_valid_d;
  logic [1:0]                                            act_sel_q, act_sel_d;
  logic                                                  lrs_sel_q, lrs_sel_d;
  logic                                                  wreg_sel_q, wreg_sel_d;
  logic                                                  busy_q, busy_d;
  logic                                                  done_q, done_d;
  logic                                                  ready_q, ready_d;
  logic                                                  w_accept, w_last;

  function automatic logic [31:0] lfsr_seed(input int unsigned r);
    return 32'hACE10000 | 32'(r);
  endfunction

  always_comb begin
    for (int unsigned r = 0; r < num_pe_row; r++) begin
      lfsr_nxt[r] = (lfsr_q[r] >> 1) ^ (lfsr_q[r][0] ? 32'h80200003 : 32'h0);
    end
  end

  assign w_accept = ready_q & w_in_valid;
  assign w_last   = (wcol_q == COL_W'(num_pe_col - 1)) && (wtap_q == TAP_W'(nb_taps - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    thr_d       = thr_q;
    wcol_d      = wcol_q;
    wtap_d      = wtap_q;
    lfsr_d      = lfsr_q;
    wreg_d      = wreg_q;
    wbpr_d      = wbpr_q;
    wetc_d      = wetc_q;
    act_d       = '0;
    act_valid_d = 1'b0;
    for (int unsigned c = 0; c < num_pe_col; c++) begin
      shadow_d[c] = act_q[num_pe_row-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d  = num_act_cycles;
          thr_d  = zero_thresh;
          cnt_d  = '0;
          wcol_d = '0;
          wtap_d = '0;
          for (int unsigned r = 0; r < num_pe_row; r++) begin
            lfsr_d[r] = lfsr_seed(r);
          end
          if (load_w)                     state_d = S_LOAD_W;
          else if (num_act_cycles == '0)  state_d = S_DONE;
          else                            state_d = S_STREAM;
        end
      end
      S_LOAD_W: begin
        if (w_accept) begin
          wreg_d[wcol_d][wtap_q*weight_width +: weight_width]         = w_in_data;
          wbpr_d[wcol_d][wtap_q*weight_bpr_width +: weight_bpr_width] = w_in_bpr;
          wetc_d[wcol_d][wtap_q*ETC_width +: ETC_width]               = w_in_etc;
          if (w_last) begin
            state_d = (num_q == '0) ? S_DONE : S_STREAM;
          end else if (wtap_q == TAP_W'(nb_taps - 1)) begin
            wtap_d = '0;
            wcol_d = wcol_q + 1'b1;
          end else begin
            wtap_d = wtap_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        // The final cycle with cnt_q == num_q is spent presenting the last registered word.
        if (cnt_q == num_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          act_valid_d = 1'b1;
          lfsr_d      = lfsr_nxt;
          for (int unsigned r = 0; r < num_pe_row; r++) begin
            if ({1'b0, lfsr_nxt[r][7:0]} < thr_q) act_d[r] = '0;
            else act_d[r] = {1'b1, lfsr_nxt[r][31 -: activation_width]};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    ready_d    = (state_d == S_LOAD_W);
    act_sel_d  = busy_d ? 2'b00 : ext_act_sel;
    lrs_sel_d  = busy_d ? 1'b0  : ext_last_row_sel;
    wreg_sel_d = busy_d ? 1'b0  : ext_wreg_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      thr_q       <= '0;
      wcol_q      <= '0;
      wtap_q      <= '0;
      for (int unsigned r = 0; r < num_pe_row; r++) begin
        lfsr_q[r] <= lfsr_seed(r);
      end
      act_q       <= '0;
      shadow_q    <= '0;
      wreg_q      <= '0;
      wbpr_q      <= '0;
      wetc_q      <= '0;
      act_valid_q <= 1'b0;
      act_sel_q   <= '0;
      lrs_sel_q   <= 1'b0;
      wreg_sel_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      thr_q       <= thr_d;
      wcol_q      <= wcol_d;
      wtap_q      <= wtap_d;
      lfsr_q      <= lfsr_d;
      act_q       <= act_d;
      shadow_q    <= shadow_d;
      wreg_q      <= wreg_d;
      wbpr_q      <= wbpr_d;
      wetc_q      <= wetc_d;
      act_valid_q <= act_valid_d;
      act_sel_q   <= act_sel_d;
      lrs_sel_q   <= lrs_sel_d;
      wreg_sel_q  <= wreg_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign compressed_act_in_fr_dummy_ctrl             = act_q;
  assign last_row_shadow_AFIFO_data_in_fr_dummy_ctrl = shadow_q;
  assign WRegs_fr_dummy_ctrl                         = wreg_q;
  assign WBPRs_fr_dummy_ctrl                         = wbpr_q;
  assign WETCs_fr_dummy_ctrl                         = wetc_q;
  assign act_valid                                   = act_valid_q;
  assign compressed_act_in_sel                       = act_sel_q;
  assign last_row_shadow_afifo_in_sel                = lrs_sel_q;
  assign wreg_in_sel                                 = wreg_sel_q;
  assign busy                                        = busy_q;
  assign done                                        = done_q;
  assign w_in_ready                                  = ready_q;

endmodule
